// File: rtl/mem_arbiter.sv
// Two-port-to-one memory arbiter: fetch and load/store share one memmodel port.
// Data wins by default; a starvation counter forces fetch through after MAX_WAIT denials.
module mem_arbiter #(
  parameter int MEMSIZE  = 256*1024,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_rready,
  output logic        m_wready,
  output logic [29:0] m_raddr,
  output logic [29:0] m_waddr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        err,
  output logic [31:0] err_addr
);

  // rtag     | meaning
  // T_NONE   | no read response due this cycle
  // T_IF     | fetch read in flight, return m_rdata on i_rdata
  // T_DATA   | data read in flight, return m_rdata on d_rdata
  // T_IF_Z   | out-of-range fetch read, return zero
  // T_DATA_Z | out-of-range data read, return zero
  localparam int AW = $clog2(MEMSIZE);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {T_NONE, T_IF, T_DATA, T_IF_Z, T_DATA_Z} rtag_t;

  rtag_t         rtag;
  logic [WW-1:0] wait_cnt;
  logic          starve;
  logic [31:0]   g_addr;
  logic          oor;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          unused_addr_bits;

  assign starve = (wait_cnt == WW'(MAX_WAIT));
  assign i_gnt  = resetb & i_req & (starve | ~d_req);
  assign d_gnt  = resetb & d_req & ~(starve & i_req);
  assign g_addr = i_gnt ? i_addr : d_addr;
  assign oor    = |g_addr[31:AW];
  assign unused_addr_bits = ^g_addr[AW-1:0];

  always_comb begin
    m_rready = 1'b0;
    m_wready = 1'b0;
    m_raddr  = '0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    if (i_gnt && !oor) begin
      m_rready = 1'b1;
      m_raddr  = i_addr[31:2];
    end else if (d_gnt && !oor) begin
      if (d_we) begin
        m_wready = 1'b1;
        m_waddr  = d_addr[31:2];
        m_wdata  = d_wdata;
        m_wstrb  = d_wstrb;
      end else begin
        m_rready = 1'b1;
        m_raddr  = d_addr[31:2];
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rtag     <= T_NONE;
      wait_cnt <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (i_gnt)
        rtag <= oor ? T_IF_Z : T_IF;
      else if (d_gnt && !d_we)
        rtag <= oor ? T_DATA_Z : T_DATA;
      else
        rtag <= T_NONE;

      if (!i_req || i_gnt)
        wait_cnt <= '0;
      else if (!starve)
        wait_cnt <= wait_cnt + WW'(1);

      err <= (i_gnt | d_gnt) & oor;
      if ((i_gnt | d_gnt) && oor)
        err_addr <= g_addr;
    end
  end

  // Non-selected port keeps showing its last returned word.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
    end
  end

  assign i_rvalid = (rtag == T_IF)   || (rtag == T_IF_Z);
  assign d_rvalid = (rtag == T_DATA) || (rtag == T_DATA_Z);

  always_comb begin
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
    case (rtag)
      T_IF:     i_rdata = m_rdata;
      T_IF_Z:   i_rdata = '0;
      T_DATA:   d_rdata = m_rdata;
      T_DATA_Z: d_rdata = '0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_mem_arbiter;
  localparam int MEMSIZE  = 256*1024;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        m_rready, m_wready;
  logic [29:0] m_raddr, m_waddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = '0;
  logic        err;
  logic [31:0] err_addr;

  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [0:65535];

  int checks = 0;
  int errors = 0;

  logic [198:0] outv;
  assign outv = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_rready, m_wready,
                 m_raddr, m_waddr, m_wdata, m_wstrb, err, err_addr};

  mem_arbiter #(.MEMSIZE(MEMSIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetb(resetb),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_rready(m_rready), .m_wready(m_wready), .m_raddr(m_raddr), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Memory model: read data one cycle after m_rready, byte-strobed writes.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (m_rready) m_rdata <= mem[m_raddr[15:0]];
    if (m_wready)
      for (int b = 0; b < 4; b++)
        if (m_wstrb[b]) mem[m_waddr[15:0]][8*b +: 8] <= m_wdata[8*b +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic clear_inputs();
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetb = 1'b0;
    tick(); tick();
    resetb = 1'b1;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    i_req = 1; d_req = 1; d_we = 1; i_addr = 32'h10; d_addr = 32'h20;
    d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hF;
    tick(); #2;
    checks++;
    if (outv !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", outv);
    end
    do_reset();
  endtask

  task automatic test_fetch_stream();
    logic [31:0] words [3];
    words = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
    do_reset();
    for (int k = 0; k < 3; k++) poke(16'(k), words[k]);
    for (int k = 0; k < 4; k++) begin
      i_req = (k < 3); i_addr = 32'(4*k);
      #2;
      checks++;
      if ({i_gnt, i_rvalid} !== {k < 3, k > 0}) begin
        errors++; $display("FAIL fetch_gnt_rvalid k=%0d got=%b want=%b", k, {i_gnt, i_rvalid}, {k < 3, k > 0});
      end
      if (k > 0) begin
        checks++;
        if (i_rdata !== words[k-1]) begin
          errors++; $display("FAIL fetch_rdata k=%0d got=%h want=%h", k, i_rdata, words[k-1]);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_contention();
    do_reset();
    poke(16'h0040, 32'hCAFE_0100);
    poke(16'h0003, 32'h0000_0333);
    i_req = 1; i_addr = 32'h0C; d_req = 1; d_we = 0; d_addr = 32'h100;
    #2;
    checks++;
    if ({i_gnt, d_gnt, m_raddr} !== {1'b0, 1'b1, 30'h40}) begin
      errors++; $display("FAIL contention_first got=%b%b raddr=%h want=01 raddr=40", i_gnt, d_gnt, m_raddr);
    end
    tick();
    d_req = 0;
    #2;
    checks++;
    if ({i_gnt, d_rvalid, d_rdata} !== {2'b11, 32'hCAFE_0100}) begin
      errors++; $display("FAIL contention_second gnt=%b dv=%b dr=%h want 1 1 cafe0100", i_gnt, d_rvalid, d_rdata);
    end
    tick();
    i_req = 0;
    #2;
    checks++;
    if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, 32'h0000_0333, 1'b0}) begin
      errors++; $display("FAIL contention_fetch_data iv=%b ir=%h dv=%b want 1 00000333 0", i_rvalid, i_rdata, d_rvalid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_starvation();
    logic [1:0] want;
    do_reset();
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0;
    for (int k = 0; k < 10; k++) begin
      d_addr = 32'(4*k);
      #2;
      want = (k == 4 || k == 9) ? 2'b10 : 2'b01;
      checks++;
      if ({i_gnt, d_gnt} !== want) begin
        errors++; $display("FAIL starve_grant k=%0d got=%b want=%b", k, {i_gnt, d_gnt}, want);
      end
      if (k == 5) begin
        checks++;
        if ({i_rvalid, d_rvalid} !== 2'b10) begin
          errors++; $display("FAIL starve_resp k=5 got=%b want=10", {i_rvalid, d_rvalid});
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_write_read();
    do_reset();
    poke(16'h0080, 32'h1122_3344);
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    #2;
    checks++;
    if ({d_gnt, m_wready, m_rready, m_waddr, m_wdata, m_wstrb} !== {3'b110, 30'h80, 32'hDEAD_BEEF, 4'b0011}) begin
      errors++; $display("FAIL write_drive got=%b%b%b %h %h %b", d_gnt, m_wready, m_rready, m_waddr, m_wdata, m_wstrb);
    end
    tick();
    d_we = 0; d_wdata = 0; d_wstrb = 0;
    #2;
    checks++;
    if ({d_gnt, m_rready, m_raddr, d_rvalid} !== {2'b11, 30'h80, 1'b0}) begin
      errors++; $display("FAIL read_drive got=%b%b %h dv=%b want 11 80 dv=0", d_gnt, m_rready, m_raddr, d_rvalid);
    end
    tick();
    d_req = 0;
    #2;
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'h1122_BEEF}) begin
      errors++; $display("FAIL write_read_data dv=%b dr=%h want 1 1122beef", d_rvalid, d_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_out_of_range();
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h0004_0000;
    #2;
    checks++;
    if ({d_gnt, m_rready, m_raddr} !== {2'b10, 30'h0}) begin
      errors++; $display("FAIL oor_grant got=%b%b raddr=%h want 10 raddr=0", d_gnt, m_rready, m_raddr);
    end
    tick();
    d_req = 0;
    #2;
    checks++;
    if ({d_rvalid, d_rdata, err, err_addr} !== {1'b1, 32'h0, 1'b1, 32'h0004_0000}) begin
      errors++; $display("FAIL oor_resp dv=%b dr=%h err=%b ea=%h want 1 0 1 00040000", d_rvalid, d_rdata, err, err_addr);
    end
    tick();
    #2;
    checks++;
    if ({d_rvalid, err, err_addr} !== {2'b00, 32'h0004_0000}) begin
      errors++; $display("FAIL oor_after dv=%b err=%b ea=%h want 0 0 00040000", d_rvalid, err, err_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    poke(16'h0000, 32'h0000_0013);
    i_req = 1; i_addr = 32'h0;
    #2;
    checks++;
    if (i_gnt !== 1'b1) begin
      errors++; $display("FAIL midreset_grant got=%b want=1", i_gnt);
    end
    tick();
    resetb = 1'b0; i_req = 0;
    #2;
    checks++;
    if (outv !== '0) begin
      errors++; $display("FAIL midreset_outputs got=%h want=0", outv);
    end
    tick(); tick();
    resetb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if ({i_rvalid, i_rdata} !== 33'h0) begin
        errors++; $display("FAIL midreset_no_rvalid k=%0d iv=%b ir=%h want 0 0", k, i_rvalid, i_rdata);
      end
      tick();
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return {24'h0, 8'($urandom)};
    if (r == 7) return 32'h0003_FFFC | 32'($urandom_range(0, 3));
    return $urandom | 32'h0004_0000;
  endfunction

  task automatic test_random();
    int mw, pk;
    logic [31:0] pv, e_ir, e_dr, e_ea, ga;
    logic e_err, eig, edg, eiv, edv, goor, emr, emw, prev_ig, prev_dg;
    logic [29:0] emra, emwa;
    logic [31:0] emwd;
    logic [3:0] emws;
    logic [198:0] expv;
    do_reset();
    for (int w = 0; w < 64; w++) ref_mem[w] = mem[w];
    ref_mem[16'hFFFF] = mem[16'hFFFF];
    mw = 0; pk = 0; pv = 0; e_ir = 0; e_dr = 0; e_ea = 0; e_err = 0;
    prev_ig = 0; prev_dg = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!i_req || prev_ig) begin
        i_req = ($urandom_range(0, 3) != 0); i_addr = rnd_addr();
      end
      if (!d_req || prev_dg) begin
        d_req = ($urandom_range(0, 3) != 0); d_we = ($urandom_range(0, 2) == 0);
        d_addr = rnd_addr(); d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
      #2;
      eig  = i_req && ((mw == MAX_WAIT) || !d_req);
      edg  = d_req && !eig;
      ga   = eig ? i_addr : d_addr;
      goor = (ga >= 32'(MEMSIZE));
      emr  = !goor && (eig || (edg && !d_we));
      emw  = !goor && edg && d_we;
      emra = emr ? ga[31:2] : 30'h0;
      emwa = emw ? ga[31:2] : 30'h0;
      emwd = emw ? d_wdata : 32'h0;
      emws = emw ? d_wstrb : 4'h0;
      eiv  = (pk == 1);
      edv  = (pk == 2);
      if (eiv) e_ir = pv;
      if (edv) e_dr = pv;
      expv = {eig, eiv, e_ir, edg, edv, e_dr, emr, emw, emra, emwa, emwd, emws, e_err, e_ea};
      checks++;
      if (outv !== expv) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, outv, expv);
      end
      pk = eig ? 1 : ((edg && !d_we) ? 2 : 0);
      pv = goor ? 32'h0 : ref_mem[ga[17:2]];
      if (emw)
        for (int b = 0; b < 4; b++)
          if (d_wstrb[b]) ref_mem[ga[17:2]][8*b +: 8] = d_wdata[8*b +: 8];
      e_err = (eig || edg) && goor;
      if (e_err) e_ea = ga;
      if (!i_req || eig) mw = 0;
      else if (mw < MAX_WAIT) mw = mw + 1;
      prev_ig = eig; prev_dg = edg;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_contention();
    test_starvation();
    test_write_read();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter that lets the IF_ID fetch path and the execute-stage load/store path share a single unified memmodel port. It sits between the core and one memmodel instance, granting one access per cycle and steering the one-cycle-late read data back to the requester that issued it. Data accesses normally win. A starvation counter guarantees that instruction fetch makes forward progress. Out-of-range addresses are flagged and never reach the memory.

## Interface
- MEMSIZE, 256*1024 — memory size in bytes (power of two); valid byte addresses are 0 .. MEMSIZE-1.
- MAX_WAIT, 4 — number of consecutive denied fetch cycles (1..15) after which fetch is forced to win.

- clk  input  1  system clock; all state updates on its rising edge.
- resetb  input  1  reset, asynchronous, active-low.
- i_req  input  1  fetch read request; held until i_gnt.
- i_addr  input  32  fetch byte address; bits [1:0] ignored.
- i_gnt  output  1  fetch request accepted this cycle.
- i_rvalid  output  1  fetch read data valid.
- i_rdata  output  32  fetch read data.
- d_req  input  1  data request; held until d_gnt.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  32  data byte address; bits [1:0] ignored.
- d_wdata  input  32  write data.
- d_wstrb  input  4  byte write strobes.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  data read data valid.
- d_rdata  output  32  data read data.
- m_rready  output  1  memory read enable.
- m_wready  output  1  memory write enable.
- m_raddr  output  30  memory read word address.
- m_waddr  output  30  memory write word address.
- m_wdata  output  32  memory write data.
- m_wstrb  output  4  memory write strobes.
- m_rdata  input  32  memory read data, valid the cycle after m_rready.
- err  output  1  one-cycle pulse: a granted access was out of range.
- err_addr  output  32  byte address of the last out-of-range access.

## Operation
- **Grant (combinational, same cycle as request):**
  - Exactly one grant or none per cycle.
  - If `starve` is set (wait_cnt == MAX_WAIT) and i_req is high, fetch wins.
  - Otherwise, if d_req is high, data wins.
  - Otherwise, if i_req is high, fetch wins.
  - All grants and memory enables are forced to 0 while resetb is low.
- **Range check:** `oor` = addr[31:$clog2(MEMSIZE)] != 0 for the granted address.
- **Memory drive for a granted access that is not `oor`:**
  - Fetch: m_rready=1, m_raddr=i_addr[31:2].
  - Data read: m_rready=1, m_raddr=d_addr[31:2].
  - Data write: m_wready=1, m_waddr=d_addr[31:2], m_wdata=d_wdata, m_wstrb=d_wstrb.
- **Memory drive otherwise:** m_rready=m_wready=0; address, data and strobe outputs are 0.
- **Out-of-range access:**
  - It is still granted, so the requester is released.
  - Next cycle err=1 and err_addr holds the address.
  - A read returns rvalid with rdata=0.
- **Response tag register `rtag` ∈ {NONE, IF, DATA, IF_Z, DATA_Z}:**
  - Loaded every cycle from the granted read; NONE for writes or idle.
  - The _Z variants mark out-of-range reads.
  - It selects which rvalid pulses and whether rdata is m_rdata or 0.
  - The rdata of the non-selected port holds its previous value.
- **Starvation counter `wait_cnt`:**
  - Width $clog2(MAX_WAIT+1).
  - Increments when i_req && !i_gnt, saturating at MAX_WAIT.
  - Clears when i_gnt is high or i_req is low.
- **Writes:** complete in the grant cycle and produce no response.

## Timing
- **Reset values:**
  - rtag=NONE, wait_cnt=0.
  - i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, err=0, err_addr=0.
  - All m_* outputs are 0.
- **Grant latency:** 0 cycles.
- **Read data latency:** exactly 1 cycle after grant.
- **Throughput:** one access per cycle, fully pipelined. A new grant may coincide with the rvalid of the previous access.
- **Simultaneous i_req and d_req with wait_cnt < MAX_WAIT:** data granted, wait_cnt increments.
- **Reset asserted mid-access:** the pending rtag is discarded; no rvalid appears after resetb rises.
- **Request dropped before grant:** this is a protocol violation. The arbiter simply re-evaluates each cycle and holds no state about it.

## Test plan
- **Fetch-only stream:** i_req held high at 0x0, 0x4, 0x8 with imem contents 0x00000013, 0x00100093, 0x00200113. Required response: i_gnt every cycle, and i_rvalid with those words on cycles 1, 2, 3.
- **Contention:** i_req and d_req (read 0x100) asserted together with MAX_WAIT=4. Required response: d_gnt first; d_rvalid with mem[0x100] one cycle later; i_gnt the next cycle.
- **Starvation:** d_req held high continuously while i_req is high. Required response: i_gnt on the 5th cycle; wait_cnt returns to 0; data resumes the following cycle.
- **Write then read same address:** write 0xDEADBEEF with wstrb=4'b0011 to 0x200 (old value 0x11223344), then read 0x200. Required response: d_rdata=0x1122BEEF.
- **Out of range:** data read at 0x00040000 with MEMSIZE=256K. Required response: d_gnt=1, m_rready=0; next cycle d_rvalid=1, d_rdata=0, err=1, err_addr=0x00040000.
- **Reset mid-read:** resetb driven low on the cycle after a fetch grant. Required response: i_rvalid is never asserted; all outputs are at reset values while resetb is low.
